mem_load_align: RTL and testbench
=================================

MEM_LOAD_ALIGN -- requirements
Module: mem_load_align

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, max cycles spent waiting for MOC (only with MEM_TIMEOUT_EN).
REQ-002 SHALL have port CLK  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port CLR  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port start  input  1  load request, sampled only in IDLE.
REQ-005 SHALL have port addr  input  32  byte address of the load.
REQ-006 SHALL have port dataSize  input  2  size code: 00 byte, 01 halfword, 10 word, 11 treated as word.
REQ-007 SHALL have port MOV  output  1  memory operation valid, read request to RAM.
REQ-008 SHALL have port memAddr  output  32  word-aligned address, i.e. {addr[31:2],2'b00}.
REQ-009 SHALL have port memRdata  input  32  RAM read word, valid while MOC=1.
REQ-010 SHALL have port MOC  input  1  memory operation complete.
REQ-011 SHALL have port Q  output  32  lane-aligned, zero-extended load data; drives the D input of signExtension.
REQ-012 SHALL have port sizeOut  output  2  latched dataSize; drives the dataSize input of signExtension.
REQ-013 SHALL have port done  output  1  one-cycle pulse; Q/sizeOut valid.
REQ-014 SHALL have port busy  output  1  high in every state except IDLE.
REQ-015 SHALL have port misalign  output  1  error flag qualified by done.
REQ-016 SHALL have port timeout  output  1  error flag qualified by done.

Function
REQ-017 SHALL implement FSM states IDLE, WAIT_MOC, WAIT_REL, DONE.
REQ-018 IDLE: on start=1 with an aligned request, SHALL latch addr and dataSize and enter WAIT_MOC; with start=0, SHALL remain in IDLE.
REQ-019 Alignment rule: a halfword with addr[0]=1 is misaligned; a word or code 11 with addr[1:0]!=0 is misaligned; a byte is never misaligned.
REQ-020 On a misaligned start, SHALL go directly to DONE with misalign=1 and Q=0, and MOV SHALL never assert.
REQ-021 WAIT_MOC: MOV SHALL be 1; when MOC=1, SHALL register the extracted lane into Q and enter WAIT_REL.
REQ-022 Lane extraction is little-endian. Byte: Q={24'b0, memRdata[8*addr[1:0]+:8]}. Halfword: Q={16'b0, memRdata[16*addr[1]+:16]}. Word: Q=memRdata.
REQ-023 WAIT_REL: MOV SHALL be 0; SHALL stay in WAIT_REL until MOC=0, then enter DONE. This completes a four-phase handshake.
REQ-024 DONE: SHALL assert done for exactly one cycle, then enter IDLE.
REQ-025 Q, sizeOut, misalign and timeout SHALL hold their values until the next request reaches DONE.
REQ-026 A start received outside IDLE SHALL be ignored; there is no queueing.
REQ-027 Latency for an aligned load, with start in cycle 0 and MOC rising in cycle k: MOV=1 from cycle 1; Q updated at the edge ending cycle k; done in the cycle after MOC is first seen low.
REQ-028 Minimum start-to-done latency SHALL be 3 cycles.
REQ-029 MOC=1 while in IDLE or DONE SHALL be ignored.

Reset
REQ-030 CLR=1 SHALL immediately force IDLE and set MOV=0, memAddr=0, Q=0, sizeOut=00, done=0, busy=0, misalign=0, timeout=0, and clear the timeout counter.
REQ-031 CLR asserted mid-handshake SHALL abort the access; MOC must then be ignored until the next start.

Configuration
REQ-032 With MEM_TIMEOUT_EN defined, a counter SHALL run in WAIT_MOC. After TIMEOUT_CYCLES cycles without MOC, the block SHALL drop MOV, enter DONE with timeout=1 and Q=0, and reset the counter on every WAIT_MOC entry.
REQ-033 Without MEM_TIMEOUT_EN, the block SHALL wait indefinitely, the timeout port SHALL remain present tied to 0, and no counter logic SHALL be built.

Structure
REQ-034 Package arm_mem_pkg SHALL hold the dataSize encodings (SIZE_BYTE=00, SIZE_HALF=01, SIZE_WORD=10) and the FSM state typedef.
REQ-035 Lane extraction SHALL be a combinational sub-module, load_lane_select (inputs memRdata, addr[1:0], dataSize; output 32-bit data), reused by the future store path.

Verification
REQ-036 Byte load: addr=0x00000101, size=00, MOC after 2 cycles, memRdata=0xF0E47492 -> Q=0x00000074, done pulse, misalign=0.
REQ-037 Halfword load: addr=0x00000102, size=01, memRdata=0xF0E47492 -> memAddr=0x00000100, Q=0x0000F0E4; sign-extended downstream to 0xFFFFF0E4.
REQ-038 Word load: addr=0x00000200, size=10, memRdata=0x0000FF03 -> Q=0x0000FF03; MOV falls the cycle after MOC rises; done only after MOC falls.
REQ-039 Misaligned word load: addr=0x00000203, size=10 -> MOV stays 0, done in cycle 1, misalign=1, Q=0; then an aligned request succeeds.
REQ-040 CLR pulse while in WAIT_MOC -> all outputs reset at once; a late MOC=1 produces no done.
REQ-041 With MEM_TIMEOUT_EN, TIMEOUT_CYCLES=16, MOC held 0 -> MOV high for 16 cycles, then done with timeout=1; without the macro, busy stays 1 indefinitely.

Source files
------------

// File: rtl/arm_mem_pkg.sv
// Shared encodings for the load/store memory path: access size codes,
// the load FSM state type and the alignment rule.
package arm_mem_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        WAIT_MOC = 2'b01,
        WAIT_REL = 2'b10,
        DONE     = 2'b11
    } state_t;

    // Size code 11 is handled exactly like a word access.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lsb);
        logic mis;
        case (size)
            SIZE_BYTE: mis = 1'b0;
            SIZE_HALF: mis = lsb[0];
            default:   mis = |lsb;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/load_lane_select.sv
// Little-endian lane extraction with zero extension; purely combinational so
// the store path can reuse it for read-modify-write merges.
module load_lane_select
    import arm_mem_pkg::*;
(
    input  logic [31:0] memRdata,
    input  logic [1:0]  addr,
    input  logic [1:0]  dataSize,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = memRdata[{addr, 3'b000} +: 8];
        half_sel = memRdata[{addr[1], 4'b0000} +: 16];
        case (dataSize)
            SIZE_BYTE: data = {24'b0, byte_sel};
            SIZE_HALF: data = {16'b0, half_sel};
            default:   data = memRdata;
        endcase
    end

endmodule

// File: rtl/mem_load_align.sv
// Aligned load unit: four-phase MOV/MOC read handshake, lane extraction and
// misalignment detection. Optional MOC wait timeout under MEM_TIMEOUT_EN.
module mem_load_align
    import arm_mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        CLK,
    input  logic        CLR,
    input  logic        start,
    input  logic [31:0] addr,
    input  logic [1:0]  dataSize,
    output logic        MOV,
    output logic [31:0] memAddr,
    input  logic [31:0] memRdata,
    input  logic        MOC,
    output logic [31:0] Q,
    output logic [1:0]  sizeOut,
    output logic        done,
    output logic        busy,
    output logic        misalign,
    output logic        timeout,
    output state_t      dbg_state
);

    // Handshake: MOV rises in WAIT_MOC and falls once MOC is seen high; the
    // access only completes after MOC has returned low (four-phase).
    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [1:0]  size_q, size_d;
    logic [31:0] data_q, data_d;
    logic        misalign_q, misalign_d;
    logic [31:0] lane_data;

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;
`endif

    load_lane_select u_lane (
        .memRdata (memRdata),
        .addr     (addr_q[1:0]),
        .dataSize (size_q),
        .data     (lane_data)
    );

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        size_d     = size_q;
        data_d     = data_q;
        misalign_d = misalign_q;
`ifdef MEM_TIMEOUT_EN
        cnt_d      = cnt_q;
        timeout_d  = timeout_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    size_d = dataSize;
                    if (is_misaligned(dataSize, addr[1:0])) begin
                        data_d     = '0;
                        misalign_d = 1'b1;
`ifdef MEM_TIMEOUT_EN
                        timeout_d  = 1'b0;
`endif
                        state_d    = DONE;
                    end else begin
                        addr_d  = addr;
`ifdef MEM_TIMEOUT_EN
                        cnt_d   = '0;
`endif
                        state_d = WAIT_MOC;
                    end
                end
            end
            WAIT_MOC: begin
                if (MOC) begin
                    data_d  = lane_data;
                    state_d = WAIT_REL;
                end
`ifdef MEM_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    data_d     = '0;
                    misalign_d = 1'b0;
                    timeout_d  = 1'b1;
                    state_d    = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            WAIT_REL: begin
                if (!MOC) begin
                    misalign_d = 1'b0;
`ifdef MEM_TIMEOUT_EN
                    timeout_d  = 1'b0;
`endif
                    state_d    = DONE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            size_q     <= '0;
            data_q     <= '0;
            misalign_q <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            cnt_q      <= '0;
            timeout_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            size_q     <= size_d;
            data_q     <= data_d;
            misalign_q <= misalign_d;
`ifdef MEM_TIMEOUT_EN
            cnt_q      <= cnt_d;
            timeout_q  <= timeout_d;
`endif
        end
    end

    assign MOV       = (state_q == WAIT_MOC);
    assign memAddr   = {addr_q[31:2], 2'b00};
    assign Q         = data_q;
    assign sizeOut   = size_q;
    assign done      = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign misalign  = misalign_q;
    assign dbg_state = state_q;
`ifdef MEM_TIMEOUT_EN
    assign timeout   = timeout_q;
`else
    assign timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_mem_load_align.sv
// Directed bench for mem_load_align: a scoreboard queue of expected
// {misalign, timeout, sizeOut, Q} tuples is popped by a monitor on every done.
module tb_mem_load_align;
    import arm_mem_pkg::*;

    logic        CLK = 1'b0;
    logic        CLR, start, MOC;
    logic [31:0] addr, memRdata;
    logic [1:0]  dataSize;
    logic        MOV, done, busy, misalign, timeout;
    logic [31:0] memAddr, Q;
    logic [1:0]  sizeOut;
    state_t      dbg_state;

    logic [35:0] exp_q[$];
    int n_cmp  = 0;
    int n_fail = 0;
    int n_done = 0;

    mem_load_align #(.TIMEOUT_CYCLES(16)) dut (
        .CLK       (CLK),
        .CLR       (CLR),
        .start     (start),
        .addr      (addr),
        .dataSize  (dataSize),
        .MOV       (MOV),
        .memAddr   (memAddr),
        .memRdata  (memRdata),
        .MOC       (MOC),
        .Q         (Q),
        .sizeOut   (sizeOut),
        .done      (done),
        .busy      (busy),
        .misalign  (misalign),
        .timeout   (timeout),
        .dbg_state (dbg_state)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest expected result.
    always @(negedge CLK) begin
        if (done === 1'b1) begin
            n_done++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_done: got Q=0x%0h with no expected entry", Q);
            end else begin
                check("done_result", {misalign, timeout, sizeOut, Q}, exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_load(input logic [31:0] a, input logic [1:0] sz, input int dly,
                           input logic [31:0] rd, input logic [31:0] exp_data);
        exp_q.push_back({1'b0, 1'b0, sz, exp_data});
        addr = a; dataSize = sz; start = 1'b1;
        tick();
        start = 1'b0;
        check("mov_rise", MOV, 1);
        check("mem_addr", memAddr, {a[31:2], 2'b00});
        repeat (dly) tick();
        check("mov_waiting", MOV, 1);
        memRdata = rd; MOC = 1'b1;
        tick();
        check("mov_fall", MOV, 0);
        check("no_done_while_moc", done, 0);
        tick();
        check("hold_in_rel", dbg_state, WAIT_REL);
        MOC = 1'b0;
        tick();
        check("done_pulse", done, 1);
        tick();
        check("done_one_cycle", done, 0);
        check("idle_after_done", busy, 0);
    endtask

    task automatic do_misaligned(input logic [31:0] a, input logic [1:0] sz);
        exp_q.push_back({1'b1, 1'b0, sz, 32'h0});
        addr = a; dataSize = sz; start = 1'b1;
        tick();
        start = 1'b0;
        check("mis_done_cycle1", done, 1);
        check("mis_no_mov", MOV, 0);
        tick();
        check("mis_idle", busy, 0);
    endtask

    initial begin
        int saved_done;
        int cnt;
        CLR = 1'b1; start = 1'b0; MOC = 1'b0;
        addr = '0; dataSize = '0; memRdata = '0;
        repeat (3) tick();
        check("rst_mov", MOV, 0);
        check("rst_memaddr", memAddr, 0);
        check("rst_q", Q, 0);
        check("rst_size", sizeOut, 0);
        check("rst_flags", {done, busy, misalign, timeout}, 0);
        CLR = 1'b0;
        tick();

        do_load(32'h0000_0101, SIZE_BYTE, 2, 32'hF0E4_7492, 32'h0000_0074);
        do_load(32'h0000_0102, SIZE_HALF, 1, 32'hF0E4_7492, 32'h0000_F0E4);
        do_load(32'h0000_0200, SIZE_WORD, 0, 32'h0000_FF03, 32'h0000_FF03);
        do_load(32'h0000_0003, SIZE_BYTE, 3, 32'h1122_3344, 32'h0000_0011);
        do_load(32'h0000_0004, 2'b11,     1, 32'hCAFE_BABE, 32'hCAFE_BABE);
        do_load(32'h0000_0206, SIZE_HALF, 0, 32'h89AB_4567, 32'h0000_89AB);
        do_load(32'h0000_0000, SIZE_BYTE, 0, 32'h89AB_4567, 32'h0000_0067);

        do_misaligned(32'h0000_0203, SIZE_WORD);
        do_misaligned(32'h0000_0101, SIZE_HALF);
        do_misaligned(32'h0000_0006, 2'b11);
        do_load(32'h0000_0300, SIZE_WORD, 1, 32'hDEAD_BEEF, 32'hDEAD_BEEF);

        // Results must persist while idle; MOC in IDLE must not start anything.
        MOC = 1'b1; memRdata = 32'h1234_5678;
        repeat (3) tick();
        check("moc_idle_ignored", busy, 0);
        check("q_holds", Q, 32'hDEAD_BEEF);
        MOC = 1'b0;
        tick();

        // A start while busy is dropped, not queued.
        exp_q.push_back({1'b0, 1'b0, SIZE_WORD, 32'h0BAD_F00D});
        addr = 32'h0000_0400; dataSize = SIZE_WORD; start = 1'b1;
        tick();
        addr = 32'h0000_0801; dataSize = SIZE_BYTE;
        tick();
        start = 1'b0;
        check("start_ignored_addr", memAddr, 32'h0000_0400);
        memRdata = 32'h0BAD_F00D; MOC = 1'b1;
        tick();
        MOC = 1'b0;
        tick();
        check("busy_start_done", done, 1);
        tick();
        tick();
        check("no_queued_req", busy, 0);

        // CLR mid-handshake aborts; a late MOC must produce no done.
        addr = 32'h0000_0500; dataSize = SIZE_HALF; start = 1'b1;
        tick();
        start = 1'b0;
        check("pre_clr_mov", MOV, 1);
        CLR = 1'b1;
        #1;
        check("clr_mov", MOV, 0);
        check("clr_busy", busy, 0);
        check("clr_outputs", {memAddr, sizeOut}, 0);
        check("clr_q", Q, 0);
        saved_done = n_done;
        tick();
        CLR = 1'b0;
        memRdata = 32'hFFFF_FFFF; MOC = 1'b1;
        repeat (4) tick();
        MOC = 1'b0;
        repeat (2) tick();
        check("no_done_after_clr", n_done, saved_done);
        check("idle_after_clr", busy, 0);

`ifdef MEM_TIMEOUT_EN
        exp_q.push_back({1'b0, 1'b1, SIZE_WORD, 32'h0});
        addr = 32'h0000_0600; dataSize = SIZE_WORD; start = 1'b1;
        tick();
        start = 1'b0;
        cnt = 0;
        while (MOV && cnt < 40) begin
            cnt++;
            tick();
        end
        check("timeout_mov_cycles", cnt, 16);
        check("timeout_done", done, 1);
        tick();
        check("timeout_idle", busy, 0);
`else
        exp_q.push_back({1'b0, 1'b0, SIZE_WORD, 32'h5555_AAAA});
        addr = 32'h0000_0600; dataSize = SIZE_WORD; start = 1'b1;
        tick();
        start = 1'b0;
        cnt = 0;
        repeat (40) begin
            tick();
            if (busy) cnt++;
        end
        check("wait_forever_busy", cnt, 40);
        check("wait_forever_mov", MOV, 1);
        memRdata = 32'h5555_AAAA; MOC = 1'b1;
        tick();
        MOC = 1'b0;
        tick();
        check("late_moc_done", done, 1);
        tick();
`endif

        repeat (3) tick();
        check("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
